credit_rx_arbiter: RTL and testbench
====================================

// Module: credit_rx_arbiter
// PURPOSE
// - Shares the single RX channel of the credit/deadlock buffer among N_REQ requesters.
// - Round-robin arbitration for fresh requests; absorbs retries by parking id+payload per requester.
// - Replays a parked request with rx_credit_o=1 after the matching credit grant arrives.
// - Sits between the requester ports and the credit/deadlock buffer RX and credit interfaces.
// PARAMETERS
// - N_REQ  4  number of requesters (2..8)
// - ID_W   3  request id width
// - PL_W   5  payload width
// PORTS
// - clk              in   1            clock
// - reset            in   1            asynchronous, active-high reset
// - req_valid_i      in   N_REQ        per-requester valid
// - req_id_i         in   N_REQ*ID_W   per-requester id; requester r uses slice r
// - req_payload_i    in   N_REQ*PL_W   per-requester payload
// - req_ready_o      out  N_REQ        request consumed (accepted downstream, or parked on retry)
// - rx_valid_o       out  1            to buffer RX valid
// - rx_id_o          out  ID_W         to buffer RX id
// - rx_payload_o     out  PL_W         to buffer RX payload
// - rx_credit_o      out  1            1 = replay of a credited, parked request
// - rx_ready_i       in   1            buffer accepts; never high in the same cycle as rx_retry_i
// - rx_retry_i       in   1            buffer rejects; request must wait for credit
// - credit_gnt_i     in   1            credit grant pulse
// - credit_id_i      in   ID_W         id of the credited request
// - parked_cnt_o     out  4            number of slots not IDLE
// - credit_orphan_o  out  1            sticky: a credit matched no PARKED slot
// BEHAVIOUR
// - Reset: all slots IDLE, RR pointer 0, lock clear; all outputs 0.
// - Per-requester slot FSM:
//   - IDLE: fresh requests allowed.
//   - IDLE -> PARKED on the cycle its fresh request sees rx_retry_i; capture id/payload and pulse req_ready_o.
//   - PARKED -> CREDITED on a credit_gnt_i whose credit_id_i equals the slot id.
//   - CREDITED -> IDLE when its replay sees rx_ready_i.
//   - PARKED and CREDITED slots hold req_ready_o[r]=0; that requester is blocked.
// - Credit match:
//   - Only the lowest-index PARKED slot with an equal id matches; one slot per credit.
//   - A slot parked in cycle t matches credits from t+1 only.
//   - No match: credit_orphan_o is set and held until reset.
// - Arbitration:
//   - Zero-cycle combinational path from the selected source to the rx_* outputs.
//   - Priority order: (1) lock holder; (2) lowest-index CREDITED slot (replay); (3) round-robin among IDLE slots with req_valid_i, starting at the pointer.
// - Lock (valid stability):
//   - Set when rx_valid_o=1 and neither rx_ready_i nor rx_retry_i is asserted.
//   - While set, the same source stays selected with unchanged data; a replay never preempts a locked fresh request.
//   - Cleared on rx_ready_i or rx_retry_i.
// - RR pointer: after a fresh request completes (ready or retry) from requester g, pointer = (g+1) mod N_REQ. Replays do not move it.
// - Handshakes:
//   - req_ready_o[g] = fresh selection of g & (rx_ready_i | rx_retry_i).
//   - A replay with rx_retry_i is a protocol error; the slot stays CREDITED and the replay is re-driven.
// - rx_credit_o = 1 only when a CREDITED slot is selected; the stored id/payload are driven.
// - Retry on requester g together with a credit for another slot: both take effect.
// - parked_cnt_o is registered, from 0 to N_REQ.
// TESTING
// - Req 0,1,2 valid, rx_ready_i=1 every cycle -> grants in order 0,1,2,0; one req_ready_o pulse per cycle.
// - Req 1 id=5 pl=0x1A; rx_retry_i -> req_ready_o[1] pulses; slot1 PARKED; parked_cnt_o=1; req_ready_o[1] stays 0 even if req_valid_i[1] is reasserted.
// - Credit id=5 -> next cycle rx_valid_o=1, rx_credit_o=1, id=5, pl=0x1A, ahead of pending req 0/2; on rx_ready_i, slot1 IDLE and parked_cnt_o=0.
// - rx_ready_i low 3 cycles with req 0 selected, then a credit arrives -> rx outputs hold req 0 until ready; replay goes out the next cycle.
// - Slots 0 and 2 both parked with id=3; one credit id=3 -> only slot0 CREDITED; a credit id=7 -> credit_orphan_o=1, sticky.
// - Assert reset with two slots parked and the lock set -> all outputs 0, parked_cnt_o=0, pointer 0; first post-reset grant goes to req 0.

Source files
------------

// File: rtl/credit_rx_arbiter.sv
// Arbitrates N_REQ requesters onto the single credit-buffer RX channel.
// Retried requests are parked per requester and replayed once their credit arrives.
module credit_rx_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 3,
    parameter int PL_W  = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*ID_W-1:0]   req_id_i,
    input  logic [N_REQ*PL_W-1:0]   req_payload_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic                    rx_valid_o,
    output logic [ID_W-1:0]         rx_id_o,
    output logic [PL_W-1:0]         rx_payload_o,
    output logic                    rx_credit_o,
    input  logic                    rx_ready_i,
    input  logic                    rx_retry_i,
    input  logic                    credit_gnt_i,
    input  logic [ID_W-1:0]         credit_id_i,
    output logic [3:0]              parked_cnt_o,
    output logic                    credit_orphan_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PARKED   = 2'd1;
    localparam logic [1:0] S_CREDITED = 2'd2;

    logic [1:0]       state_q   [N_REQ];
    logic [1:0]       state_d   [N_REQ];
    logic [ID_W-1:0]  slot_id_q [N_REQ];
    logic [ID_W-1:0]  slot_id_d [N_REQ];
    logic [PL_W-1:0]  slot_pl_q [N_REQ];
    logic [PL_W-1:0]  slot_pl_d [N_REQ];

    logic             lock_q, lock_d;
    logic             lock_replay_q, lock_replay_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [ID_W-1:0]  lock_id_q, lock_id_d;
    logic [PL_W-1:0]  lock_pl_q, lock_pl_d;

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0]       parked_cnt_q, parked_cnt_d;
    logic             orphan_q, orphan_d;

    logic [ID_W-1:0]  req_id [N_REQ];
    logic [PL_W-1:0]  req_pl [N_REQ];

    logic             sel_valid, sel_replay;
    logic [IDX_W-1:0] sel_idx;
    logic [ID_W-1:0]  sel_id;
    logic [PL_W-1:0]  sel_pl;
    logic             fire;

    always_comb begin
        for (int r = 0; r < N_REQ; r++) begin
            req_id[r] = req_id_i[r*ID_W +: ID_W];
            req_pl[r] = req_payload_i[r*PL_W +: PL_W];
        end
    end

    // Source select: lock holder, then lowest CREDITED slot, then round-robin fresh.
    always_comb begin
        int idx;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sel_valid  = 1'b0;
        sel_replay = 1'b0;
        sel_idx    = '0;
        sel_id     = '0;
        sel_pl     = '0;
        idx        = 0;
        if (lock_q) begin
            sel_valid  = 1'b1;
            sel_replay = lock_replay_q;
            sel_idx    = lock_idx_q;
            sel_id     = lock_id_q;
            sel_pl     = lock_pl_q;
        end else begin
            for (int r = N_REQ - 1; r >= 0; r--) begin
                if (state_q[r] == S_CREDITED) begin
                    sel_valid  = 1'b1;
                    sel_replay = 1'b1;
                    sel_idx    = IDX_W'(r);
                end
            end
            if (sel_valid) begin
                sel_id = slot_id_q[sel_idx];
                sel_pl = slot_pl_q[sel_idx];
            end else begin
                for (int i = N_REQ - 1; i >= 0; i--) begin
                    idx = (int'(rr_ptr_q) + i) % N_REQ;
                    if (req_valid_i[idx] && state_q[idx] == S_IDLE) begin
                        sel_valid = 1'b1;
                        sel_idx   = IDX_W'(idx);
                    end
                end
                if (sel_valid) begin
                    sel_id = req_id[sel_idx];
                    sel_pl = req_pl[sel_idx];
                end
            end
        end
    end

    assign rx_valid_o   = sel_valid & ~reset;
    assign rx_id_o      = rx_valid_o ? sel_id : '0;
    assign rx_payload_o = rx_valid_o ? sel_pl : '0;
    assign rx_credit_o  = rx_valid_o & sel_replay;
    assign fire         = rx_valid_o & (rx_ready_i | rx_retry_i);

    always_comb begin
        req_ready_o = '0;
        if (fire && !sel_replay) begin
            req_ready_o[sel_idx] = 1'b1;
        end
    end

    always_comb begin
        logic             match;
        logic [IDX_W-1:0] match_idx;
        state_d       = state_q;
        slot_id_d     = slot_id_q;
        slot_pl_d     = slot_pl_q;
        orphan_d      = orphan_q;
        rr_ptr_d      = rr_ptr_q;
        lock_d        = 1'b0;
        lock_replay_d = lock_replay_q;
        lock_idx_d    = lock_idx_q;
        lock_id_d     = lock_id_q;
        lock_pl_d     = lock_pl_q;
        parked_cnt_d  = '0;
        match         = 1'b0;
        match_idx     = '0;

        if (fire && !sel_replay) begin
            rr_ptr_d = (sel_idx == IDX_W'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;
            if (rx_retry_i) begin
                state_d[sel_idx]   = S_PARKED;
                slot_id_d[sel_idx] = sel_id;
                slot_pl_d[sel_idx] = sel_pl;
            end
        end
        // A retried replay is a protocol error: the slot simply stays CREDITED.
        if (rx_valid_o && sel_replay && rx_ready_i) begin
            state_d[sel_idx] = S_IDLE;
        end

        // Matching on registered state keeps a slot parked this cycle out of reach.
        for (int r = N_REQ - 1; r >= 0; r--) begin
            if (state_q[r] == S_PARKED && slot_id_q[r] == credit_id_i) begin
                match     = 1'b1;
                match_idx = IDX_W'(r);
            end
        end
        if (credit_gnt_i) begin
            if (match) begin
                state_d[match_idx] = S_CREDITED;
            end else begin
                orphan_d = 1'b1;
            end
        end

        if (rx_valid_o && !rx_ready_i && !rx_retry_i) begin
            lock_d        = 1'b1;
            lock_replay_d = sel_replay;
            lock_idx_d    = sel_idx;
            lock_id_d     = sel_id;
            lock_pl_d     = sel_pl;
        end

        for (int r = 0; r < N_REQ; r++) begin
            if (state_d[r] != S_IDLE) begin
                parked_cnt_d = parked_cnt_d + 4'd1;
            end
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < N_REQ; r++) begin
                state_q[r] <= S_IDLE;
            end
            lock_q        <= 1'b0;
            lock_replay_q <= 1'b0;
            lock_idx_q    <= '0;
            lock_id_q     <= '0;
            lock_pl_q     <= '0;
            rr_ptr_q      <= '0;
            parked_cnt_q  <= '0;
            orphan_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            lock_q        <= lock_d;
            lock_replay_q <= lock_replay_d;
            lock_idx_q    <= lock_idx_d;
            lock_id_q     <= lock_id_d;
            lock_pl_q     <= lock_pl_d;
            rr_ptr_q      <= rr_ptr_d;
            parked_cnt_q  <= parked_cnt_d;
            orphan_q      <= orphan_d;
        end
    end

    // NOTE: slot id/payload storage has no reset; it is only read while the slot is not IDLE.
    always_ff @(posedge clk) begin
        slot_id_q <= slot_id_d;
        slot_pl_q <= slot_pl_d;
    end

    assign parked_cnt_o    = parked_cnt_q;
    assign credit_orphan_o = orphan_q;

endmodule

// File: tb/tb_credit_rx_arbiter.sv
// Table-driven bench for credit_rx_arbiter; expectations flow through a scoreboard queue.
module tb_credit_rx_arbiter;

    localparam int N  = 4;
    localparam int IW = 3;
    localparam int PW = 5;

    localparam logic [19:0] PLS   = {5'h13, 5'h12, 5'h1A, 5'h10};
    localparam logic [11:0] IDS_A = {3'd6, 3'd3, 3'd5, 3'd2};
    localparam logic [11:0] IDS_B = {3'd6, 3'd3, 3'd5, 3'd3};

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid_i = '0;
    logic [N*IW-1:0] req_id_i = '0;
    logic [N*PW-1:0] req_payload_i = '0;
    logic [N-1:0]   req_ready_o;
    logic           rx_valid_o;
    logic [IW-1:0]  rx_id_o;
    logic [PW-1:0]  rx_payload_o;
    logic           rx_credit_o;
    logic           rx_ready_i = 1'b0;
    logic           rx_retry_i = 1'b0;
    logic           credit_gnt_i = 1'b0;
    logic [IW-1:0]  credit_id_i = '0;
    logic [3:0]     parked_cnt_o;
    logic           credit_orphan_o;

    always #5 clk = ~clk;

    credit_rx_arbiter #(.N_REQ(N), .ID_W(IW), .PL_W(PW)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid_i     (req_valid_i),
        .req_id_i        (req_id_i),
        .req_payload_i   (req_payload_i),
        .req_ready_o     (req_ready_o),
        .rx_valid_o      (rx_valid_o),
        .rx_id_o         (rx_id_o),
        .rx_payload_o    (rx_payload_o),
        .rx_credit_o     (rx_credit_o),
        .rx_ready_i      (rx_ready_i),
        .rx_retry_i      (rx_retry_i),
        .credit_gnt_i    (credit_gnt_i),
        .credit_id_i     (credit_id_i),
        .parked_cnt_o    (parked_cnt_o),
        .credit_orphan_o (credit_orphan_o)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic [3:0]  vld;
        logic [11:0] ids;
        logic        rdy;
        logic        rty;
        logic        cg;
        logic [2:0]  cid;
        logic        e_vld;
        logic [2:0]  e_id;
        logic [4:0]  e_pl;
        logic        e_cr;
        logic [3:0]  e_rr;
        logic [3:0]  e_cnt;
        logic        e_orph;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t v(string n, logic rst, logic [3:0] vld, logic [11:0] ids,
                               logic rdy, logic rty, logic cg, logic [2:0] cid,
                               logic ev, logic [2:0] eid, logic [4:0] epl, logic ecr,
                               logic [3:0] err, logic [3:0] ecnt, logic eorph);
        vec_t t;
        t.name = n; t.rst = rst; t.vld = vld; t.ids = ids;
        t.rdy = rdy; t.rty = rty; t.cg = cg; t.cid = cid;
        t.e_vld = ev; t.e_id = eid; t.e_pl = epl; t.e_cr = ecr;
        t.e_rr = err; t.e_cnt = ecnt; t.e_orph = eorph;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expectation pushed for this cycle and compares mid-cycle.
    always @(negedge clk) begin
        vec_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.name, ".rx_valid"},   32'(rx_valid_o),      32'(e.e_vld));
            check({e.name, ".rx_id"},      32'(rx_id_o),         32'(e.e_id));
            check({e.name, ".rx_payload"}, 32'(rx_payload_o),    32'(e.e_pl));
            check({e.name, ".rx_credit"},  32'(rx_credit_o),     32'(e.e_cr));
            check({e.name, ".req_ready"},  32'(req_ready_o),     32'(e.e_rr));
            check({e.name, ".parked_cnt"}, 32'(parked_cnt_o),    32'(e.e_cnt));
            check({e.name, ".orphan"},     32'(credit_orphan_o), 32'(e.e_orph));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // name, rst, vld, ids, rdy, rty, cg, cid | vld, id, pl, credit, ready, cnt, orphan
        tbl.push_back(v("rst_hold",     1, 4'b0111, IDS_A, 1, 0, 0, 3'd0, 0, 3'd0, 5'h00, 0, 4'b0000, 4'd0, 0));
        // Round-robin with ready every cycle: 0,1,2,0
        tbl.push_back(v("rr_g0",        0, 4'b0111, IDS_A, 1, 0, 0, 3'd0, 1, 3'd2, 5'h10, 0, 4'b0001, 4'd0, 0));
        tbl.push_back(v("rr_g1",        0, 4'b0111, IDS_A, 1, 0, 0, 3'd0, 1, 3'd5, 5'h1A, 0, 4'b0010, 4'd0, 0));
        tbl.push_back(v("rr_g2",        0, 4'b0111, IDS_A, 1, 0, 0, 3'd0, 1, 3'd3, 5'h12, 0, 4'b0100, 4'd0, 0));
        tbl.push_back(v("rr_g0b",       0, 4'b0111, IDS_A, 1, 0, 0, 3'd0, 1, 3'd2, 5'h10, 0, 4'b0001, 4'd0, 0));
        // Retry parks requester 1, credit id 5 triggers replay ahead of fresh requests
        tbl.push_back(v("park1",        0, 4'b0010, IDS_A, 0, 1, 0, 3'd0, 1, 3'd5, 5'h1A, 0, 4'b0010, 4'd0, 0));
        tbl.push_back(v("blocked1",     0, 4'b0010, IDS_A, 0, 0, 0, 3'd0, 0, 3'd0, 5'h00, 0, 4'b0000, 4'd1, 0));
        tbl.push_back(v("credit5",      0, 4'b0000, IDS_A, 0, 0, 1, 3'd5, 0, 3'd0, 5'h00, 0, 4'b0000, 4'd1, 0));
        tbl.push_back(v("replay_wait",  0, 4'b0101, IDS_A, 0, 0, 0, 3'd0, 1, 3'd5, 5'h1A, 1, 4'b0000, 4'd1, 0));
        tbl.push_back(v("replay_done",  0, 4'b0101, IDS_A, 1, 0, 0, 3'd0, 1, 3'd5, 5'h1A, 1, 4'b0000, 4'd1, 0));
        tbl.push_back(v("after_replay", 0, 4'b0101, IDS_A, 1, 0, 0, 3'd0, 1, 3'd3, 5'h12, 0, 4'b0100, 4'd0, 0));
        // Locked fresh request is not preempted by a credit arriving mid-stall
        tbl.push_back(v("park3",        0, 4'b1000, IDS_A, 0, 1, 0, 3'd0, 1, 3'd6, 5'h13, 0, 4'b1000, 4'd0, 0));
        tbl.push_back(v("lock_c1",      0, 4'b0001, IDS_A, 0, 0, 0, 3'd0, 1, 3'd2, 5'h10, 0, 4'b0000, 4'd1, 0));
        tbl.push_back(v("lock_c2",      0, 4'b0001, IDS_A, 0, 0, 0, 3'd0, 1, 3'd2, 5'h10, 0, 4'b0000, 4'd1, 0));
        tbl.push_back(v("lock_c3_cred", 0, 4'b0001, IDS_A, 0, 0, 1, 3'd6, 1, 3'd2, 5'h10, 0, 4'b0000, 4'd1, 0));
        tbl.push_back(v("lock_release", 0, 4'b0001, IDS_A, 1, 0, 0, 3'd0, 1, 3'd2, 5'h10, 0, 4'b0001, 4'd1, 0));
        tbl.push_back(v("replay3",      0, 4'b0001, IDS_A, 1, 0, 0, 3'd0, 1, 3'd6, 5'h13, 1, 4'b0000, 4'd1, 0));
        tbl.push_back(v("rr_after",     0, 4'b0001, IDS_A, 1, 0, 0, 3'd0, 1, 3'd2, 5'h10, 0, 4'b0001, 4'd0, 0));
        // Slots 0 and 2 parked with id 3; one credit hits slot 0 only; id 7 is orphan
        tbl.push_back(v("park2",        0, 4'b0101, IDS_B, 0, 1, 0, 3'd0, 1, 3'd3, 5'h12, 0, 4'b0100, 4'd0, 0));
        tbl.push_back(v("park0",        0, 4'b0101, IDS_B, 0, 1, 0, 3'd0, 1, 3'd3, 5'h10, 0, 4'b0001, 4'd1, 0));
        tbl.push_back(v("credit3",      0, 4'b0000, IDS_B, 0, 0, 1, 3'd3, 0, 3'd0, 5'h00, 0, 4'b0000, 4'd2, 0));
        tbl.push_back(v("orphan7",      0, 4'b0000, IDS_B, 0, 0, 1, 3'd7, 1, 3'd3, 5'h10, 1, 4'b0000, 4'd2, 0));
        tbl.push_back(v("orph_sticky",  0, 4'b0000, IDS_B, 0, 0, 0, 3'd0, 1, 3'd3, 5'h10, 1, 4'b0000, 4'd2, 1));
        // Reset with parked slots and lock set
        tbl.push_back(v("mid_reset",    1, 4'b0101, IDS_B, 0, 0, 0, 3'd0, 0, 3'd0, 5'h00, 0, 4'b0000, 4'd0, 0));
        tbl.push_back(v("post_rst_g0",  0, 4'b0111, IDS_B, 1, 0, 0, 3'd0, 1, 3'd3, 5'h10, 0, 4'b0001, 4'd0, 0));
        // Credit in the parking cycle does not match; retry plus credit both apply
        tbl.push_back(v("park_same",    0, 4'b0010, IDS_B, 0, 1, 1, 3'd5, 1, 3'd5, 5'h1A, 0, 4'b0010, 4'd0, 0));
        tbl.push_back(v("retry_credit", 0, 4'b0100, IDS_B, 0, 1, 1, 3'd5, 1, 3'd3, 5'h12, 0, 4'b0100, 4'd1, 1));
        tbl.push_back(v("replay_retry", 0, 4'b0000, IDS_B, 0, 1, 0, 3'd0, 1, 3'd5, 5'h1A, 1, 4'b0000, 4'd2, 1));
        tbl.push_back(v("replay_again", 0, 4'b0000, IDS_B, 1, 0, 0, 3'd0, 1, 3'd5, 5'h1A, 1, 4'b0000, 4'd2, 1));
        tbl.push_back(v("final_idle",   0, 4'b0000, IDS_B, 0, 0, 0, 3'd0, 0, 3'd0, 5'h00, 0, 4'b0000, 4'd1, 1));

        repeat (2) @(posedge clk);
        for (int k = 0; k < tbl.size(); k++) begin
            @(posedge clk);
            #1;
            reset         = tbl[k].rst;
            req_valid_i   = tbl[k].vld;
            req_id_i      = tbl[k].ids;
            req_payload_i = PLS;
            rx_ready_i    = tbl[k].rdy;
            rx_retry_i    = tbl[k].rty;
            credit_gnt_i  = tbl[k].cg;
            credit_id_i   = tbl[k].cid;
            sb.push_back(tbl[k]);
        end
        @(posedge clk);
        #1;
        req_valid_i  = '0;
        rx_ready_i   = 1'b0;
        rx_retry_i   = 1'b0;
        credit_gnt_i = 1'b0;
        @(posedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
